// File: rtl/alu_seq16_if.sv
// Request/result bundle for the multi-byte ALU sequencer.
// The master drives operands and start; the slave returns status, result and flags.
interface alu_seq16_if #(
  parameter int NBYTE = 2
);
  logic                 start;
  logic [1:0]           op;
  logic [8*NBYTE-1:0]   opa;
  logic [8*NBYTE-1:0]   opb;
  logic                 cin;
  logic                 busy;
  logic                 done;
  logic [8*NBYTE-1:0]   res;
  logic                 fcy;
  logic                 fz;
  logic                 fs;
  logic                 fv;

  modport master (
    output start, op, opa, opb, cin,
    input  busy, done, res, fcy, fz, fs, fv
  );

  modport slave (
    input  start, op, opa, opb, cin,
    output busy, done, res, fcy, fz, fs, fv
  );
endinterface

// File: rtl/alu_seq16.sv
// Multi-byte ADD/ADC/SUB/SBB sequencer: one 8-bit ripple adder is reused
// LSB-first across NBYTE passes, carry chained through a register.
module add8b #(
  parameter int DATASIZE = 8
) (
  input  logic [DATASIZE-1:0] iA,
  input  logic [DATASIZE-1:0] iB,
  input  logic                iC,
  output logic [DATASIZE-1:0] oS,
  output logic [DATASIZE-1:0] oC
);
  logic c;

  // oC exposes every internal carry so the caller can form overflow from bits 7 and 6
  always_comb begin
    c  = iC;
    oS = '0;
    oC = '0;
    for (int i = 0; i < DATASIZE; i++) begin
      oS[i] = iA[i] ^ iB[i] ^ c;
      c     = (iA[i] & iB[i]) | (c & (iA[i] ^ iB[i]));
      oC[i] = c;
    end
  end
endmodule

module alu_seq16 #(
  parameter int NBYTE = 2,
  parameter int DSIZE = 8
) (
  input  logic         clk,
  input  logic         rstn,
  alu_seq16_if.slave   bus
);
  localparam int W = 8 * NBYTE;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q;
  logic [W-1:0]       a_q;
  logic [W-1:0]       b_q;
  logic [W-1:0]       rsh_q;
  logic [W-1:0]       res_q;
  logic [1:0]         op_q;
  logic [2:0]         idx_q;
  logic               cy_q;
  logic               zacc_q;
  logic               busy_q;
  logic               done_q;
  logic               fcy_q;
  logic               fz_q;
  logic               fs_q;
  logic               fv_q;

  logic [DSIZE-1:0]   add_a;
  logic [DSIZE-1:0]   add_b;
  logic [DSIZE-1:0]   add_s;
  logic [DSIZE-1:0]   add_c;
  logic [W-1:0]       res_d;
  logic               zacc_d;
  logic               cy_init_d;
  logic               last_d;

  // Subtraction is a + ~b + carry, so the B byte is inverted for SUB/SBB
  always_comb begin
    add_a     = a_q[DSIZE-1:0];
    add_b     = op_q[1] ? ~b_q[DSIZE-1:0] : b_q[DSIZE-1:0];
    res_d     = {add_s, rsh_q[W-1:DSIZE]};
    zacc_d    = zacc_q & (add_s == '0);
    last_d    = (idx_q == 3'(NBYTE - 1));
    cy_init_d = 1'b0;
    case (bus.op)
      2'b00:   cy_init_d = 1'b0;
      2'b01:   cy_init_d = bus.cin;
      2'b10:   cy_init_d = 1'b1;
      2'b11:   cy_init_d = ~bus.cin;
      default: cy_init_d = 1'b0;
    endcase
  end

  add8b #(.DATASIZE(DSIZE)) u_add (
    .iA (add_a),
    .iB (add_b),
    .iC (cy_q),
    .oS (add_s),
    .oC (add_c)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      rsh_q   <= '0;
      res_q   <= '0;
      op_q    <= '0;
      idx_q   <= '0;
      cy_q    <= 1'b0;
      zacc_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fcy_q   <= 1'b0;
      fz_q    <= 1'b0;
      fs_q    <= 1'b0;
      fv_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_q     <= bus.opa;
            b_q     <= bus.opb;
            op_q    <= bus.op;
            idx_q   <= '0;
            cy_q    <= cy_init_d;
            zacc_q  <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          a_q    <= {{DSIZE{1'b0}}, a_q[W-1:DSIZE]};
          b_q    <= {{DSIZE{1'b0}}, b_q[W-1:DSIZE]};
          rsh_q  <= res_d;
          cy_q   <= add_c[DSIZE-1];
          zacc_q <= zacc_d;
          idx_q  <= idx_q + 3'd1;
          // Final byte: result and all flags are published on the same edge
          if (last_d) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            res_q   <= res_d;
            fcy_q   <= op_q[1] ? ~add_c[DSIZE-1] : add_c[DSIZE-1];
            fz_q    <= zacc_d;
            fs_q    <= add_s[DSIZE-1];
            fv_q    <= add_c[DSIZE-1] ^ add_c[DSIZE-2];
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.res  = res_q;
  assign bus.fcy  = fcy_q;
  assign bus.fz   = fz_q;
  assign bus.fs   = fs_q;
  assign bus.fv   = fv_q;
endmodule

// File: tb/tb_alu_seq16.sv
// Bench for alu_seq16 at NBYTE=2 and NBYTE=4: directed cases, handshake,
// abort and random operations against an arithmetic reference model.
module tb_alu_seq16;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_ADC = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_SBB = 2'b11;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_seq16_if #(.NBYTE(2)) if2 ();
  alu_seq16_if #(.NBYTE(4)) if4 ();

  alu_seq16 #(.NBYTE(2), .DSIZE(8)) u2 (.clk(clk), .rstn(rstn), .bus(if2));
  alu_seq16 #(.NBYTE(4), .DSIZE(8)) u4 (.clk(clk), .rstn(rstn), .bus(if4));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int nb, input logic st, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic cin);
    if (nb == 2) begin
      if2.start = st; if2.op = op; if2.opa = a[15:0]; if2.opb = b[15:0]; if2.cin = cin;
    end else begin
      if4.start = st; if4.op = op; if4.opa = a;       if4.opb = b;       if4.cin = cin;
    end
  endtask

  task automatic sample(input int nb, output logic bs, output logic dn, output logic [31:0] r,
                        output logic cy, output logic z, output logic s, output logic v);
    if (nb == 2) begin
      bs = if2.busy; dn = if2.done; r = {16'h0, if2.res};
      cy = if2.fcy;  z = if2.fz;    s = if2.fs; v = if2.fv;
    end else begin
      bs = if4.busy; dn = if4.done; r = if4.res;
      cy = if4.fcy;  z = if4.fz;    s = if4.fs; v = if4.fv;
    end
  endtask

  // Plain integer arithmetic: unsigned for carry/borrow, signed range for overflow
  task automatic model(input int nb, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic cin, output logic [31:0] r,
                       output logic cy, output logic z, output logic s, output logic v);
    longint m, ua, ub, sa, sb, c, t, st;
    m  = longint'(1) << (8 * nb);
    ua = longint'({32'h0, a}) & (m - 1);
    ub = longint'({32'h0, b}) & (m - 1);
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    c  = (op[0] && cin) ? 1 : 0;
    if (!op[1]) begin
      t = ua + ub + c; st = sa + sb + c; cy = (t >= m);
    end else begin
      t = ua - ub - c; st = sa - sb - c; cy = (t < 0);
    end
    v = (st >= m / 2) || (st < -(m / 2));
    r = 32'(t & (m - 1));
    z = (r == 32'h0);
    s = r[8*nb-1];
  endtask

  // Call at a negedge right after start has been driven; returns at the done negedge
  task automatic finish_op(input int nb, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic cin, input bit mid,
                           input bit chk_hold, input logic [31:0] hold_val,
                           output logic [31:0] er);
    logic [31:0] r;
    logic ecy, ez, es, ev, bs, dn, cy, z, s, v;
    int cyc, busyc;
    bit seen;
    model(nb, op, a, b, cin, er, ecy, ez, es, ev);
    cyc = 0; busyc = 0; seen = 0; bs = 1'b0;
    @(posedge clk);
    while (!seen && cyc < 3 * nb + 4) begin
      @(negedge clk);
      cyc++;
      sample(nb, bs, dn, r, cy, z, s, v);
      if (dn === 1'b1) seen = 1;
      else begin
        if (bs === 1'b1) busyc++;
        if (chk_hold) check("res_hold", r, hold_val);
      end
      if (mid && cyc == 1) drive(nb, 1'b1, ~op, ~a, b ^ 32'h5a5a5a5a, ~cin);
      else                 drive(nb, 1'b0, op, a, b, cin);
    end
    check("done_seen", 32'(seen), 32'd1);
    check("done_latency", 32'(cyc), 32'(nb + 1));
    check("busy_cycles", 32'(busyc), 32'(nb));
    check("busy_at_done", 32'(bs), 32'd0);
    check("res", r, er);
    check("fcy", 32'(cy), 32'(ecy));
    check("fz", 32'(z), 32'(ez));
    check("fs", 32'(s), 32'(es));
    check("fv", 32'(v), 32'(ev));
  endtask

  task automatic run_op(input int nb, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic cin, input bit mid,
                        output logic [31:0] er);
    logic [31:0] r;
    logic bs, dn, cy, z, s, v;
    @(negedge clk);
    drive(nb, 1'b1, op, a, b, cin);
    finish_op(nb, op, a, b, cin, mid, 1'b0, 32'h0, er);
    @(negedge clk);
    sample(nb, bs, dn, r, cy, z, s, v);
    check("done_pulse_end", 32'(dn), 32'd0);
    check("res_held", r, er);
  endtask

  initial begin
    logic [31:0] er, er2, r, ra, rb;
    logic bs, dn, cy, z, s, v, rc;
    logic [1:0] rop;
    int nb;

    // Reset held with start asserted
    drive(2, 1'b1, OP_ADD, 32'h1234, 32'h1111, 1'b0);
    drive(4, 1'b1, OP_ADD, 32'h1234, 32'h1111, 1'b0);
    repeat (3) @(negedge clk);
    for (int k = 2; k <= 4; k += 2) begin
      sample(k, bs, dn, r, cy, z, s, v);
      check("rst_busy", 32'(bs), 32'd0);
      check("rst_done", 32'(dn), 32'd0);
      check("rst_res", r, 32'h0);
      check("rst_flags", {28'h0, cy, z, s, v}, 32'h0);
    end
    drive(2, 1'b0, OP_ADD, 32'h0, 32'h0, 1'b0);
    drive(4, 1'b0, OP_ADD, 32'h0, 32'h0, 1'b0);
    rstn = 1'b1;
    repeat (3) begin
      @(negedge clk);
      sample(2, bs, dn, r, cy, z, s, v);
      check("idle_done", 32'(dn), 32'd0);
      check("idle_busy", 32'(bs), 32'd0);
    end

    // Directed NBYTE=2 cases
    run_op(2, OP_ADD, 32'h12FF, 32'h0001, 1'b0, 1'b0, er); check("add_12ff", er, 32'h1300);
    run_op(2, OP_ADD, 32'hFFFF, 32'h0001, 1'b0, 1'b0, er); check("add_ffff", er, 32'h0000);
    run_op(2, OP_ADC, 32'h7FFF, 32'h0000, 1'b1, 1'b0, er); check("adc_7fff", er, 32'h8000);
    run_op(2, OP_SUB, 32'h1000, 32'h0001, 1'b0, 1'b0, er); check("sub_1000", er, 32'h0FFF);
    run_op(2, OP_SUB, 32'h0000, 32'h0001, 1'b0, 1'b0, er); check("sub_0000", er, 32'hFFFF);
    run_op(2, OP_SBB, 32'h0005, 32'h0005, 1'b1, 1'b0, er); check("sbb_5_5", er, 32'hFFFF);

    // start pulsed during RUN must be ignored
    run_op(2, OP_ADD, 32'h1234, 32'h4321, 1'b0, 1'b1, er); check("mid_start", er, 32'h5555);

    // Back-to-back: start sampled in the DONE cycle
    @(negedge clk);
    drive(2, 1'b1, OP_ADD, 32'h0102, 32'h0304, 1'b0);
    finish_op(2, OP_ADD, 32'h0102, 32'h0304, 1'b0, 1'b0, 1'b0, 32'h0, er);
    drive(2, 1'b1, OP_SUB, 32'h0500, 32'h0600, 1'b0);
    finish_op(2, OP_SUB, 32'h0500, 32'h0600, 1'b0, 1'b0, 1'b1, er, er2);
    check("chain_res", er2, 32'hFF00);
    @(negedge clk);
    sample(2, bs, dn, r, cy, z, s, v);
    check("chain_done_end", 32'(dn), 32'd0);

    // Abort in the second RUN cycle
    @(negedge clk);
    drive(2, 1'b1, OP_ADD, 32'h1234, 32'h1111, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive(2, 1'b0, OP_ADD, 32'h0, 32'h0, 1'b0);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    sample(2, bs, dn, r, cy, z, s, v);
    check("abort_busy", 32'(bs), 32'd0);
    check("abort_done", 32'(dn), 32'd0);
    check("abort_res", r, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (4) begin
      @(negedge clk);
      sample(2, bs, dn, r, cy, z, s, v);
      check("abort_no_done", 32'(dn), 32'd0);
    end
    run_op(2, OP_ADD, 32'h00FF, 32'h0001, 1'b0, 1'b0, er); check("post_abort", er, 32'h0100);

    // NBYTE=4 directed cases
    run_op(4, OP_ADD, 32'h000012FF, 32'h00000001, 1'b0, 1'b0, er); check("add4_12ff", er, 32'h00001300);
    run_op(4, OP_ADD, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, er); check("add4_ffff", er, 32'h0);
    run_op(4, OP_SUB, 32'h00001000, 32'h00000001, 1'b0, 1'b0, er); check("sub4_1000", er, 32'h00000FFF);
    run_op(4, OP_SUB, 32'h00000000, 32'h00000001, 1'b0, 1'b0, er); check("sub4_0000", er, 32'hFFFFFFFF);

    // Random operations on both widths
    for (int i = 0; i < 32; i++) begin
      nb  = (i % 2 == 0) ? 2 : 4;
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = (i % 5 == 0) ? ra : $urandom;
      rc  = 1'($urandom_range(0, 1));
      if (nb == 2) begin ra = ra & 32'hFFFF; rb = rb & 32'hFFFF; end
      run_op(nb, rop, ra, rb, rc, 1'b0, er);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_seq16.md
# alu_seq16

Multi-byte arithmetic sequencer for the 8085 core ALU. It runs ADD, ADC, SUB and SBB on operands NBYTE bytes wide by stepping one shared add8b instance through the operand bytes, least-significant byte first. The carry is chained between passes through an internal register. It serves 16-bit operations such as DAD and register-pair arithmetic without a second adder, and reports 8085-style flags when the operation completes.

## Interface
- NBYTE, default 2: operand width in bytes; legal range 2..4.
- DSIZE, default 8: adder slice width; fixed at 8 and passed to the add8b DATASIZE parameter.
- clk, input, 1: rising-edge clock.
- rstn, input, 1: asynchronous active-low reset.
- start, input, 1: request; sampled only when the sequencer can accept.
- op, input, 2: operation; 00 ADD, 01 ADC, 10 SUB, 11 SBB.
- opa, input, 8*NBYTE: operand A.
- opb, input, 8*NBYTE: operand B.
- cin, input, 1: carry-in for ADC, borrow-in for SBB; ignored for ADD and SUB.
- busy, output, 1: a pass is in progress.
- done, output, 1: one-cycle completion pulse.
- res, output, 8*NBYTE: result; held until the next completion.
- fcy, output, 1: carry (ADD/ADC) or borrow (SUB/SBB).
- fz, output, 1: whole result equals zero.
- fs, output, 1: result MSB.
- fv, output, 1: signed overflow.

## Operation
- States: IDLE, RUN, DONE.
- IDLE or DONE with start=1:
  - Capture opa, opb and op into shift registers.
  - Set byte index to 0.
  - Load the carry register with the initial carry: ADD 0, ADC cin, SUB 1, SBB ~cin.
  - Go to RUN.
- IDLE or DONE with start=0: go to or stay in IDLE.
- RUN, per cycle:
  - Adder inputs (combinational): iA = low byte of the A shift register; iB = low byte of the B shift register, inverted for SUB/SBB; iC = carry register.
  - On the clock edge: write oS into the result shift register at the top byte and shift down by 8 bits. Load the carry register from oC[7].
  - Clear the zero accumulator if oS is nonzero. Increment the index.
  - On the last byte (index = NBYTE-1), latch v = oC[7]^oC[6] and go to DONE.
- DONE: update res, fcy, fz, fs and fv together. fcy = final carry for ADD/ADC and ~final carry for SUB/SBB. fs = res MSB.
- Flag outputs hold until the next DONE.
- start while in RUN is ignored: no queuing and no error.
- All arithmetic is modulo 2^(8*NBYTE). Operands are unsigned for fcy and two's complement for fv.

## Timing
- Reset, asynchronous: state IDLE. busy, done, res, fcy, fz, fs, fv and all internal registers are 0.
- Reset asserted mid-RUN aborts immediately. No done pulse is produced and res is not updated.
- Latency: start is sampled at edge E0. busy goes high after E0 and stays high through edge E(NBYTE-1). done is high for the one cycle between E(NBYTE) and E(NBYTE+1), with res and flags valid from E(NBYTE).
- NBYTE=2 therefore gives done two cycles after the start edge.
- Back-to-back operation: start sampled high during the DONE cycle begins the next operation at that edge. busy rises with no idle gap. res holds the previous value until the new DONE.
- busy and done are never high together.
- The adder path is combinational from registers within one cycle. No other combinational path exists from inputs to outputs.

## Test plan
- Reset: hold rstn low with start=1 -> busy=0, done=0, res=0, all flags 0. After release with start=0 the block stays IDLE with no done.
- ADD, NBYTE=2: 0x12FF + 0x0001 -> res=0x1300, fcy=0, fz=0, fs=0, fv=0. done exactly 2 cycles after the start edge; busy high for 2 cycles. Also 0xFFFF + 0x0001 -> 0x0000, fcy=1, fz=1.
- ADC: 0x7FFF + 0x0000 with cin=1 -> res=0x8000, fs=1, fv=1, fcy=0.
- SUB: 0x1000 - 0x0001 -> 0x0FFF, fcy=0. SUB 0x0000 - 0x0001 -> 0xFFFF, fcy=1, fs=1. SBB 0x0005 - 0x0005 with cin=1 -> 0xFFFF, fcy=1, fz=0.
- Handshake: pulse start again during RUN -> ignored, result is from the first request only. Hold start high through DONE -> second operation starts with no gap and its done follows 2 cycles later.
- Abort: assert rstn low during the second RUN cycle -> busy=0 and res=0 immediately, no done. A new operation after release produces the correct result. Repeat the ADD and SUB cases with NBYTE=4 and check that done arrives 4 cycles after start.
